// File: rtl/uv_recon_sched_pkg.sv
// uv_recon_sched_pkg: shared state encoding, DC-error slice layout and default sizes.
package uv_recon_sched_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int TOP_DERR_LSB = 0;
  localparam int TOP_DERR_W = 32;
  localparam int LEFT_DERR_LSB = 16;
  localparam int LEFT_DERR_W = 32;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT_IN = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN = 3'd3;
  localparam logic [2:0] ST_OUT = 3'd4;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    WAIT_IN = ST_WAIT_IN,
    START = ST_START,
    RUN = ST_RUN,
    OUT = ST_OUT
  } state_e;
endpackage

// File: rtl/uv_recon_sched_if.sv
// uv_recon_sched_if: frame control, loader/datapath/downstream handshakes of the scheduler.
interface uv_recon_sched_if;
  logic frame_start;
  logic [9:0] mb_w, mb_h;
  logic busy, frame_done;
  logic in_valid, in_ready;
  logic rec_start;
  logic [9:0] rec_x, rec_y;
  logic rec_top_derr_en;
  logic [9:0] rec_top_derr_addr;
  logic [31:0] rec_top_derr, rec_left_derr;
  logic [47:0] rec_derr;
  logic rec_done;
  logic out_valid, out_ready;
  logic err;
  modport master (
    input frame_start, mb_w, mb_h, in_valid, rec_top_derr_en, rec_top_derr_addr, rec_derr, rec_done, out_ready,
    output busy, frame_done, in_ready, rec_start, rec_x, rec_y, rec_top_derr, rec_left_derr, out_valid, err
  );
  modport slave (
    output frame_start, mb_w, mb_h, in_valid, rec_top_derr_en, rec_top_derr_addr, rec_derr, rec_done, out_ready,
    input busy, frame_done, in_ready, rec_start, rec_x, rec_y, rec_top_derr, rec_left_derr, out_valid, err
  );
endinterface

// File: rtl/uv_derr_ram.sv
// uv_derr_ram: simple dual-port top-error store, registered read-first output.
module uv_derr_ram #(
  parameter int ADDR_W = 10,
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [W-1:0]      wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [W-1:0]      q
);
  logic [W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (re) q <= mem[ra];
endmodule

// File: rtl/uv_recon_sched.sv
// uv_recon_sched: raster macroblock scheduler for chroma reconstruction; UV_RECON_SCHED_TIMEOUT_EN adds a RUN watchdog.
module uv_recon_sched
  import uv_recon_sched_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
`ifdef UV_RECON_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input logic clk,
  input logic rst,
  uv_recon_sched_if.master sif
);
  logic [2:0] state;
  logic [9:0] w, h, x, y;
  logic [LEFT_DERR_W-1:0] left;
  logic [TOP_DERR_W-1:0] top_q;
  logic fd, last_col, last_mb, tmo;
  assign last_col = x == w - 10'd1;
  assign last_mb = last_col && y == h - 10'd1;
  assign sif.busy = state != ST_IDLE;
  assign sif.frame_done = fd;
  assign sif.in_ready = state == ST_WAIT_IN;
  assign sif.rec_start = state == ST_START;
  assign sif.out_valid = state == ST_OUT;
  assign sif.rec_x = x;
  assign sif.rec_y = y;
  // Stale store contents from a previous frame are hidden in row 0.
  assign sif.rec_top_derr = y == 10'd0 ? '0 : top_q;
  assign sif.rec_left_derr = x == 10'd0 ? '0 : left;
  uv_derr_ram #(.ADDR_W(ADDR_W), .W(TOP_DERR_W)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(state == ST_RUN && sif.rec_done),
    .wa(x[ADDR_W-1:0]),
    .wd(sif.rec_derr[TOP_DERR_LSB +: TOP_DERR_W]),
    .re(sif.rec_top_derr_en),
    .ra(sif.rec_top_derr_addr[ADDR_W-1:0]),
    .q(top_q)
  );
`ifdef UV_RECON_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  logic err_q;
  assign tmo = state == ST_RUN && !sif.rec_done && cnt == CW'(TIMEOUT_CYC - 1);
  assign sif.err = err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= state == ST_RUN && !tmo ? cnt + 1'b1 : '0;
      if (tmo) err_q <= 1'b1;
      else if (state == ST_IDLE && sif.frame_start) err_q <= 1'b0;
    end
`else
  assign tmo = 1'b0;
  assign sif.err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      w <= '0;
      h <= '0;
      x <= '0;
      y <= '0;
      left <= '0;
      fd <= 1'b0;
    end else begin
      fd <= 1'b0;
      case (state)
        ST_IDLE: if (sif.frame_start) begin
          w <= sif.mb_w;
          h <= sif.mb_h;
          x <= '0;
          y <= '0;
          left <= '0;
          if (sif.mb_w == 10'd0 || sif.mb_h == 10'd0) fd <= 1'b1;
          else state <= ST_WAIT_IN;
        end
        ST_WAIT_IN: if (sif.in_valid) state <= ST_START;
        ST_START: state <= ST_RUN;
        ST_RUN: if (sif.rec_done) begin
          left <= sif.rec_derr[LEFT_DERR_LSB +: LEFT_DERR_W];
          state <= ST_OUT;
        end else if (tmo) state <= ST_IDLE;
        ST_OUT: if (sif.out_ready) begin
          x <= last_col ? '0 : x + 10'd1;
          y <= last_col ? y + 10'd1 : y;
          if (last_col) left <= '0;
          fd <= last_mb;
          state <= last_mb ? ST_IDLE : ST_WAIT_IN;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uv_recon_sched.sv
// tb_uv_recon_sched: randomized frames against a raster-order reference model of the scheduler.
module tb_uv_recon_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] mem_m [1024];
  uv_recon_sched_if bus ();
  uv_recon_sched #(
    .ADDR_W(10)
`ifdef UV_RECON_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start_frame(input int w, input int h);
    bus.frame_start = 1'b1;
    bus.mb_w = 10'(w);
    bus.mb_h = 10'(h);
    step();
    bus.frame_start = 1'b0;
  endtask
  task automatic run_frame(input int w, input int h, input int stall, input bit use_d00, input logic [47:0] d00);
    logic [31:0] left_m;
    left_m = '0;
    start_frame(w, h);
    check("busy_after_start", bus.busy, 1);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        logic [47:0] d;
        logic [31:0] exp_top;
        int a, ns;
        bit last;
        last = x == w - 1 && y == h - 1;
        check("in_ready", bus.in_ready, 1);
        check("err_idle", bus.err, 0);
        repeat ($urandom_range(0, 2)) step();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("rec_start", bus.rec_start, 1);
        check("rec_x", bus.rec_x, 64'(x));
        check("rec_y", bus.rec_y, 64'(y));
        check("in_ready_start", bus.in_ready, 0);
        check("left_derr", bus.rec_left_derr, x == 0 ? 32'd0 : left_m);
        a = x == 0 ? 0 : int'($urandom_range(0, w - 1));
        exp_top = y == 0 ? 32'd0 : mem_m[a];
        bus.rec_top_derr_en = 1'b1;
        bus.rec_top_derr_addr = 10'(a);
        step();
        bus.rec_top_derr_en = 1'b0;
        check("rec_start_pulse", bus.rec_start, 0);
        check("top_derr", bus.rec_top_derr, exp_top);
        bus.frame_start = 1'b1;
        bus.mb_w = 10'($urandom_range(0, 7));
        bus.in_valid = 1'b1;
        step();
        bus.frame_start = 1'b0;
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) step();
        check("out_valid_run", bus.out_valid, 0);
        d[47:32] = 16'($urandom());
        d[31:0] = $urandom();
        if (use_d00 && x == 0 && y == 0) d = d00;
        exp_top = y == 0 ? 32'd0 : mem_m[x];
        bus.rec_done = 1'b1;
        bus.rec_derr = d;
        bus.rec_top_derr_en = 1'b1;
        bus.rec_top_derr_addr = 10'(x);
        step();
        bus.rec_done = 1'b0;
        bus.rec_top_derr_en = 1'b0;
        check("out_valid", bus.out_valid, 1);
        check("in_ready_out", bus.in_ready, 0);
        check("top_derr_rd_first", bus.rec_top_derr, exp_top);
        mem_m[x] = d[31:0];
        left_m = d[47:16];
        check("left_derr_out", bus.rec_left_derr, x == 0 ? 32'd0 : left_m);
        ns = stall >= 0 ? stall : int'($urandom_range(0, 3));
        repeat (ns) begin
          step();
          check("stall_out_valid", bus.out_valid, 1);
          check("stall_in_ready", bus.in_ready, 0);
          check("stall_rec_x", bus.rec_x, 64'(x));
          check("stall_rec_y", bus.rec_y, 64'(y));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("frame_done", bus.frame_done, last ? 1 : 0);
        check("busy_after_out", bus.busy, last ? 0 : 1);
        if (!last) check("in_ready_next", bus.in_ready, 1);
        if (x == w - 1) left_m = '0;
      end
    step();
    check("frame_done_once", bus.frame_done, 0);
  endtask
  initial begin
    bus.frame_start = 1'b0;
    bus.mb_w = '0;
    bus.mb_h = '0;
    bus.in_valid = 1'b0;
    bus.rec_top_derr_en = 1'b0;
    bus.rec_top_derr_addr = '0;
    bus.rec_derr = '0;
    bus.rec_done = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_rec_start", bus.rec_start, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_rec_x", bus.rec_x, 0);
    check("rst_rec_y", bus.rec_y, 0);
    check("rst_top", bus.rec_top_derr, 0);
    check("rst_left", bus.rec_left_derr, 0);
    rst = 1'b0;
    step();
    run_frame(2, 2, 0, 1'b1, 48'h1234_5678_0000);
    run_frame(2, 2, 10, 1'b1, 48'h0000_DEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      start_frame(i == 0 ? 0 : 3, i == 0 ? 4 : 0);
      check("zero_frame_done", bus.frame_done, 1);
      check("zero_busy", bus.busy, 0);
      check("zero_rec_start", bus.rec_start, 0);
      step();
      check("zero_done_once", bus.frame_done, 0);
      check("zero_in_ready", bus.in_ready, 0);
    end
    for (int i = 0; i < 6; i++)
      run_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)), -1, 1'b0, '0);
    start_frame(3, 2);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
`ifdef UV_RECON_SCHED_TIMEOUT_EN
    repeat (15) step();
    check("wd_busy_before", bus.busy, 1);
    check("wd_err_before", bus.err, 0);
    step();
    check("wd_err", bus.err, 1);
    check("wd_busy", bus.busy, 0);
    check("wd_no_frame_done", bus.frame_done, 0);
    run_frame(2, 1, 0, 1'b0, '0);
    check("wd_err_cleared", bus.err, 0);
`else
    repeat (40) step();
    check("nowd_busy", bus.busy, 1);
    check("nowd_err", bus.err, 0);
    check("nowd_out_valid", bus.out_valid, 0);
    check("nowd_frame_done", bus.frame_done, 0);
`endif
    start_frame(4, 3);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_rec_x", bus.rec_x, 0);
    check("abort_err", bus.err, 0);
    step();
    rst = 1'b0;
    bus.rec_done = 1'b1;
    bus.rec_derr = 48'hFFFF_FFFF_FFFF;
    step();
    bus.rec_done = 1'b0;
    check("late_done_out_valid", bus.out_valid, 0);
    check("late_done_busy", bus.busy, 0);
    run_frame(3, 2, -1, 1'b0, '0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
